sdram_arbiter: RTL and testbench

Two-port arbiter and cycle sequencer in front of the TMS99000 SDRAM controller. It accepts word read/write requests from port A (CPU) and port B (video/DMA), launches one controller machine cycle at a time by pulsing `as`, holds address, data and direction stable for the full cycle, and returns read data with a one-cycle acknowledge. When both ports are idle it inserts dummy reads so the controller's per-cycle auto-refresh keeps running.

---
 rtl/sdram_arbiter.sv | 148 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter and cycle sequencer in front of the TMS99000 SDRAM controller.
// Build option SDRAM_ARB_RR_EN selects round-robin arbitration; without it port A has fixed priority.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | power-up wait, down-counter init_cnt runs to terminal count 0
// ST_IDLE | arbitrate every clock; grant or dummy refresh launches a cycle
// ST_RUN  | machine cycle in flight, cyc_cnt counts c = 0 .. CYCLE_LEN-2
module sdram_arbiter #(
  parameter int CYCLE_LEN = 18,
  parameter int RD_LAT    = 9,
  parameter int RFSH_INT  = 900,
  parameter int INIT_WAIT = 32
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [23:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [23:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,
  output logic        b_ack,
  output logic [23:0] sd_ad,
  output logic [15:0] sd_din,
  output logic        sd_nwr,
  output logic        sd_as,
  input  logic [15:0] sd_dout
);

  localparam int CW = $clog2(CYCLE_LEN);
  localparam int IW = $clog2(INIT_WAIT + 1);
  localparam int RW = $clog2(RFSH_INT + 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] init_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [RW-1:0] idle_cnt;
  logic          gnt_a, gnt_b, gnt_rfsh, launch, rd_point;
  logic          own_a, own_b;
`ifdef SDRAM_ARB_RR_EN
  logic          last_b;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // The single IDLE clock doubles as the closing clock of the machine cycle,
  // so back-to-back launches land exactly CYCLE_LEN clocks apart.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == '0) state_nxt = ST_IDLE;
      ST_IDLE: if (launch) state_nxt = ST_RUN;
      ST_RUN:  if (cyc_cnt == CW'(CYCLE_LEN - 2)) state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    gnt_rfsh = 1'b0;
    if (state == ST_IDLE) begin
`ifdef SDRAM_ARB_RR_EN
      gnt_a = a_req && (!b_req || last_b);
`else
      gnt_a = a_req;
`endif
      gnt_b    = b_req && !gnt_a;
      gnt_rfsh = !a_req && !b_req && (idle_cnt == RW'(RFSH_INT - 1));
    end
  end

  assign launch   = gnt_a | gnt_b | gnt_rfsh;
  assign rd_point = (state == ST_RUN) && (cyc_cnt == CW'(RD_LAT));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      init_cnt <= IW'(INIT_WAIT - 1);
      cyc_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      if (state == ST_INIT && init_cnt != '0) init_cnt <= init_cnt - IW'(1);
      if (launch)                cyc_cnt <= '0;
      else if (state == ST_RUN)  cyc_cnt <= cyc_cnt + CW'(1);
      if (launch)                              idle_cnt <= '0;
      else if (idle_cnt != RW'(RFSH_INT - 1))  idle_cnt <= idle_cnt + RW'(1);
    end
  end

`ifdef SDRAM_ARB_RR_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)        last_b <= 1'b1;
    else if (gnt_a) last_b <= 1'b0;
    else if (gnt_b) last_b <= 1'b1;
  end
`endif

  // Dummy refresh cycles are reads of address 0 owned by neither port.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sd_as   <= 1'b0;
      sd_ad   <= '0;
      sd_din  <= '0;
      sd_nwr  <= 1'b1;
      own_a   <= 1'b0;
      own_b   <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      sd_as <= launch;
      if (launch) begin
        own_a <= gnt_a;
        own_b <= gnt_b;
        if (gnt_a) begin
          sd_ad  <= a_addr;
          sd_din <= a_wdata;
          sd_nwr <= !a_we;
        end else if (gnt_b) begin
          sd_ad  <= b_addr;
          sd_din <= b_wdata;
          sd_nwr <= !b_we;
        end else begin
          sd_ad  <= '0;
          sd_din <= '0;
          sd_nwr <= 1'b1;
        end
      end
      a_ack <= rd_point && own_a;
      b_ack <= rd_point && own_b;
      if (rd_point && own_a && sd_nwr) a_rdata <= sd_dout;
      if (rd_point && own_b && sd_nwr) b_rdata <= sd_dout;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: timeline-based reference model plus directed and random traffic.
// Follows SDRAM_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  localparam int CYCLE_LEN = 18;
  localparam int RD_LAT    = 9;
  localparam int RFSH_INT  = 900;
  localparam int INIT_WAIT = 32;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [23:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0, sd_dout = '0;
  logic [15:0] a_rdata, b_rdata, sd_din;
  logic        a_ack, b_ack, sd_nwr, sd_as;
  logic [23:0] sd_ad;

  always #5 clk_in = ~clk_in;

  sdram_arbiter #(.CYCLE_LEN(CYCLE_LEN), .RD_LAT(RD_LAT), .RFSH_INT(RFSH_INT), .INIT_WAIT(INIT_WAIT)) dut (
    .clk_in(clk_in), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .sd_ad(sd_ad), .sd_din(sd_din), .sd_nwr(sd_nwr), .sd_as(sd_as), .sd_dout(sd_dout)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: times are interval indices since reset release.
  int          m_k, m_ready, m_launch, m_idle_base, m_port;  // m_port: 0 dummy/none, 1 A, 2 B
  bit          m_we, m_last_b, e_din_chk;
  logic [23:0] m_addr, e_ad;
  logic [15:0] e_din, e_a_rdata, e_b_rdata;
  logic        e_as, e_nwr, e_a_ack, e_b_ack;
  logic [15:0] mem [logic [23:0]];

  function automatic logic [15:0] mem_word(input logic [23:0] ad);
    if (!mem.exists(ad)) mem[ad] = 16'($urandom);
    return mem[ad];
  endfunction

  task automatic model_reset();
    m_k = 0; m_ready = INIT_WAIT; m_launch = -1000; m_idle_base = 0; m_port = 0;
    m_we = 1'b0; m_last_b = 1'b1; m_addr = '0;
    e_as = 1'b0; e_ad = '0; e_din = '0; e_nwr = 1'b1; e_din_chk = 1'b1;
    e_a_ack = 1'b0; e_b_ack = 1'b0; e_a_rdata = '0; e_b_rdata = '0;
  endtask

  task automatic model_step();
    int g;
    if (m_port != 0 && !m_we && m_k == m_launch + RD_LAT) begin
      if (m_port == 1) e_a_rdata = sd_dout;
      else             e_b_rdata = sd_dout;
    end
    if (m_k >= m_ready) begin
      g = 0;
      if (a_req && b_req) g = (RR && !m_last_b) ? 2 : 1;
      else if (a_req)     g = 1;
      else if (b_req)     g = 2;
      if (g != 0 || (m_k - m_idle_base) >= RFSH_INT - 1) begin
        m_launch = m_k + 1; m_ready = m_k + CYCLE_LEN; m_idle_base = m_k + 1; m_port = g;
        if (g == 1)      begin m_we = a_we; m_addr = a_addr; e_din = a_wdata; end
        else if (g == 2) begin m_we = b_we; m_addr = b_addr; e_din = b_wdata; end
        else             begin m_we = 1'b0; m_addr = '0; end
        e_ad = m_addr; e_nwr = !m_we; e_din_chk = (g != 0);
        if (g != 0 && m_we) mem[m_addr] = e_din;
        if (g != 0) m_last_b = (g == 2);
      end
    end
    m_k++;
    e_as    = (m_k == m_launch);
    e_a_ack = (m_port == 1 && m_k == m_launch + RD_LAT + 1);
    e_b_ack = (m_port == 2 && m_k == m_launch + RD_LAT + 1);
  endtask

  always @(posedge clk_in) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("sd_as", 32'(sd_as), 32'(e_as));
    chk("sd_ad", 32'(sd_ad), 32'(e_ad));
    chk("sd_nwr", 32'(sd_nwr), 32'(e_nwr));
    if (e_din_chk) chk("sd_din", 32'(sd_din), 32'(e_din));
    chk("a_ack", 32'(a_ack), 32'(e_a_ack));
    chk("b_ack", 32'(b_ack), 32'(e_b_ack));
    chk("a_rdata", 32'(a_rdata), 32'(e_a_rdata));
    chk("b_rdata", 32'(b_rdata), 32'(e_b_rdata));
  end

  // Stimulus side: one tick per falling edge; also plays the controller's dout.
  int cyc = 0, last_as = 0;

  task automatic tick();
    @(negedge clk_in);
    cyc++;
    if (sd_as) last_as = cyc;
    if (m_port != 0 && !m_we && m_k == m_launch + RD_LAT) sd_dout = mem_word(m_addr);
    else                                                 sd_dout = 16'($urandom);
  endtask

  // which: 0 sd_as, 1 a_ack, 2 b_ack
  task automatic wait_sig(input int which, input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if ((which == 0 && sd_as) || (which == 1 && a_ack) || (which == 2 && b_ack)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: event %0d not seen within %0d clocks", which, bound);
    end
  endtask

  task automatic new_req(input bit port_b);
    if (!port_b) begin
      a_req = 1'b1; a_we = 1'($urandom_range(1)); a_addr = 24'h100000 | 24'($urandom_range(15)); a_wdata = 16'($urandom);
    end else begin
      b_req = 1'b1; b_we = 1'($urandom_range(1)); b_addr = 24'h100000 | 24'($urandom_range(15)); b_wdata = 16'($urandom);
    end
  endtask

  initial begin
    int t, t0, t2, t3, nd, acks;
    int ts[6];
    logic [23:0] ads[6];
    int dt[2];
    bit seen_ack, a_acked, b_acked;

    // Reset values and first write on port A
    repeat (3) tick();
    chk("rst_sd_as", 32'(sd_as), 32'h0);
    chk("rst_sd_nwr", 32'(sd_nwr), 32'h1);
    chk("rst_sd_ad", 32'(sd_ad), 32'h0);
    chk("rst_sd_din", 32'(sd_din), 32'h0);
    chk("rst_acks", 32'({a_ack, b_ack}), 32'h0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'h0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 24'h000123; a_wdata = 16'hBEEF;
    rst = 1'b0; t0 = cyc;
    wait_sig(0, 100, t);
    chk("init_wait_first_as", 32'(t - t0), 32'd33);
    chk("wr_sd_ad", 32'(sd_ad), 32'h000123);
    chk("wr_sd_nwr", 32'(sd_nwr), 32'h0);
    chk("wr_sd_din", 32'(sd_din), 32'hBEEF);
    wait_sig(1, 40, t2);
    chk("wr_ack_c", 32'(t2 - t), 32'd10);
    tick(); a_req = 1'b0;

    // Port B reads back the word
    tick(); b_req = 1'b1; b_we = 1'b0; b_addr = 24'h000123;
    wait_sig(2, 60, t);
    chk("b_rdata_beef", 32'(b_rdata), 32'hBEEF);
    chk("a_rdata_kept", 32'(a_rdata), 32'h0);
    tick(); b_req = 1'b0;

    // Both ports requesting continuously
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 24'h0000AA;
    b_req = 1'b1; b_we = 1'b0; b_addr = 24'h0000BB;
    for (int j = 0; j < 6; j++) begin
      wait_sig(0, 60, t);
      ts[j] = t; ads[j] = sd_ad;
    end
    for (int j = 0; j < 6; j++) begin
      chk("contend_order", 32'(ads[j]), (RR && (j % 2 == 1)) ? 32'h0000BB : 32'h0000AA);
      if (j > 0) chk("contend_spacing", 32'(ts[j] - ts[j-1]), 32'd18);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a_ack || b_ack) break;
    end
    tick(); a_req = 1'b0; b_req = 1'b0;

    // Idle for 2000 clocks: dummy refresh cycles only
    t3 = last_as; nd = 0; acks = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (a_ack || b_ack) acks++;
      if (sd_as) begin
        chk("dummy_ad", 32'(sd_ad), 32'h0);
        chk("dummy_nwr", 32'(sd_nwr), 32'h1);
        if (nd < 2) dt[nd] = cyc - t3;
        t3 = cyc; nd++;
      end
    end
    chk("dummy_count", 32'(nd), 32'd2);
    chk("dummy_first_gap", 32'(dt[0]), 32'd900);
    chk("dummy_second_gap", 32'(dt[1]), 32'd900);
    chk("dummy_no_ack", 32'(acks), 32'd0);

    // Request on the clock the idle counter reaches RFSH_INT-1
    t0 = last_as;
    while (cyc < t0 + RFSH_INT - 1) tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 24'h00ABCD; b_wdata = 16'h1234;
    wait_sig(0, 5, t);
    chk("collide_as_time", 32'(t - t0), 32'd900);
    chk("collide_ad", 32'(sd_ad), 32'h00ABCD);
    chk("collide_nwr", 32'(sd_nwr), 32'h0);
    wait_sig(2, 30, t2);
    chk("collide_ack_c", 32'(t2 - t), 32'd10);
    tick(); b_req = 1'b0;
    wait_sig(0, 1000, t3);
    chk("collide_idle_restart", 32'(t3 - t), 32'd900);
    chk("collide_next_dummy_ad", 32'(sd_ad), 32'h0);

    // Reset in the middle of a read
    tick(); a_req = 1'b1; a_we = 1'b0; a_addr = 24'h000123;
    wait_sig(0, 60, t);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("abort_sd_as", 32'(sd_as), 32'h0);
    chk("abort_sd_nwr", 32'(sd_nwr), 32'h1);
    chk("abort_sd_ad", 32'(sd_ad), 32'h0);
    chk("abort_a_rdata", 32'(a_rdata), 32'h0);
    chk("abort_a_ack", 32'(a_ack), 32'h0);
    repeat (2) tick();
    rst = 1'b0; t0 = cyc; seen_ack = 1'b0; t = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (a_ack) seen_ack = 1'b1;
      if (sd_as) begin t = cyc; break; end
    end
    chk("abort_no_ack", 32'(seen_ack), 32'h0);
    chk("abort_init_repeat", 32'(t - t0), 32'd33);
    wait_sig(1, 30, t2);
    tick(); a_req = 1'b0;

    // Random traffic, with a quiet stretch long enough for a refresh
    a_acked = 1'b0; b_acked = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (a_acked) begin
        a_acked = 1'b0;
        if ($urandom_range(1) == 1 && !(i > 2000 && i < 3500)) new_req(1'b0); else a_req = 1'b0;
      end else if (a_req && a_ack) a_acked = 1'b1;
      else if (!a_req && $urandom_range(7) == 0 && !(i > 2000 && i < 3500)) new_req(1'b0);
      if (b_acked) begin
        b_acked = 1'b0;
        if ($urandom_range(1) == 1 && !(i > 2000 && i < 3500)) new_req(1'b1); else b_req = 1'b0;
      end else if (b_req && b_ack) b_acked = 1'b1;
      else if (!b_req && $urandom_range(7) == 0 && !(i > 2000 && i < 3500)) new_req(1'b1);
    end
    for (int i = 0; i < 60 && (a_req || b_req); i++) begin
      tick();
      if (a_req && a_ack) a_req = 1'b0;
      if (b_req && b_ack) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
